// File: rtl/diff_stim_pkg.sv
// Shared types and helpers for the differential stimulus player/checker.
//   state_e    : controller states
//   idx_w      : width of the vector index / first_fail_idx for a given NUM_VEC
//   lfsr_step  : one Galois LFSR advance of a w-bit value
//   misr_step  : one MISR update (rotate-left-by-1, then XOR the new sample)
// The helpers work on MAX_W-bit containers plus an explicit width so one
// definition serves every IN_W/OUT_W. Callers size-cast the result back down.
package diff_stim_pkg;

  localparam int MAX_W = 1024;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRIVE    = 2'd1,
    ST_WAIT_VEC = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  function automatic int idx_w(input int num_vec);
    return (num_vec < 1) ? 1 : $clog2(num_vec + 1);
  endfunction

  function automatic logic [MAX_W-1:0] width_mask(input int w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  // next = {cur[w-2:0],0} ^ (cur[w-1] ? poly : 0)
  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] cur,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int               w);
    logic [MAX_W-1:0] nxt;
    nxt = (cur << 1) & width_mask(w);
    if (|((cur >> (w - 1)) & MAX_W'(1))) nxt = nxt ^ poly;
    return nxt & width_mask(w);
  endfunction

  function automatic logic [MAX_W-1:0] misr_step(input logic [MAX_W-1:0] sig,
                                                 input logic [MAX_W-1:0] y,
                                                 input int               w);
    logic [MAX_W-1:0] rot;
    rot = ((sig << 1) | (sig >> (w - 1))) & width_mask(w);
    return (rot ^ y) & width_mask(w);
  endfunction

endpackage

// File: rtl/diff_stim_compare_stim_lfsr.sv
// Galois LFSR stimulus source.
//   clk, rst : clock, synchronous active-high reset (reloads the seed)
//   load     : reload the seed
//   advance  : step the LFSR once (load has priority)
//   lfsr     : current LFSR value
// A zero seed would lock the LFSR at zero, so it is replaced by 1.
module stim_lfsr
  import diff_stim_pkg::*;
#(
  parameter int              IN_W = 255,
  parameter logic [IN_W-1:0] POLY = IN_W'('h1D),
  parameter logic [IN_W-1:0] SEED = IN_W'(1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            advance,
  output logic [IN_W-1:0] lfsr
);

  localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;

  logic [IN_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED_EFF;
    end else if (advance) begin
      lfsr_d = IN_W'(lfsr_step(MAX_W'(lfsr_q), MAX_W'(POLY), IN_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED_EFF;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/diff_stim_compare.sv
// Stimulus player and differential checker. Drives one vector (all-zero
// first, then NUM_VEC LFSR or external vectors) into NUM_CH channels, samples
// every channel at the end of each hold window, flags channels that differ
// from channel 0 and folds channel 0 into a MISR signature.
//   clk, rst              : clock, synchronous active-high reset
//   start, mode           : begin a run; mode 0 = LFSR, 1 = external vectors
//   ext_vec/valid/ready   : external vector handshake (mode 1)
//   stim                  : vector driven to all channels
//   dut_y                 : channel outputs, channel i at [i*OUT_W +: OUT_W]
//   busy, done            : run status (done sticks until next start/rst)
//   mismatch, mismatch_ch : sticky mismatch flags (bit 0 always 0)
//   first_fail_idx        : vector index of the first mismatching sample
//   sig                   : channel-0 MISR
//
// state       | meaning
// ST_IDLE     | waiting for start after reset
// ST_DRIVE    | holding stim for HOLD_CYC cycles, sample on the last one
// ST_WAIT_VEC | external mode, waiting for ext_valid (no timeout)
// ST_DONE     | run finished, results held until start
module diff_stim_compare
  import diff_stim_pkg::*;
#(
  parameter int              IN_W     = 255,
  parameter int              OUT_W    = 152,
  parameter int              NUM_CH   = 2,
  parameter int              NUM_VEC  = 20,
  parameter int              HOLD_CYC = 1,
  parameter logic [IN_W-1:0] POLY     = IN_W'('h1D),
  parameter logic [IN_W-1:0] SEED     = IN_W'(1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           mode,
  input  logic [IN_W-1:0]                ext_vec,
  input  logic                           ext_valid,
  output logic                           ext_ready,
  output logic [IN_W-1:0]                stim,
  input  logic [NUM_CH*OUT_W-1:0]        dut_y,
  output logic                           busy,
  output logic                           done,
  output logic                           mismatch,
  output logic [NUM_CH-1:0]              mismatch_ch,
  output logic [idx_w(NUM_VEC)-1:0]      first_fail_idx,
  output logic [OUT_W-1:0]               sig
);

  localparam int IDX_W  = idx_w(NUM_VEC);
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VEC);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYC - 1);

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [IN_W-1:0]     stim_q, stim_d;
  logic [OUT_W-1:0]    sig_q, sig_d;
  logic [NUM_CH-1:0]   mismatch_ch_q, mismatch_ch_d;
  logic [IDX_W-1:0]    first_fail_q, first_fail_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                lfsr_load, lfsr_adv;
  logic [IN_W-1:0]     lfsr_val;
  logic [OUT_W-1:0]    y0;
  logic [NUM_CH-1:0]   diff_now;

  stim_lfsr #(.IN_W(IN_W), .POLY(POLY), .SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .lfsr    (lfsr_val)
  );

  assign y0 = dut_y[OUT_W-1:0];

  // Channel 0 is the reference, so its flag bit can never set.
  always_comb begin
    diff_now = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      diff_now[i] = (dut_y[i*OUT_W +: OUT_W] != y0);
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    idx_d         = idx_q;
    hold_d        = hold_q;
    stim_d        = stim_q;
    sig_d         = sig_q;
    mismatch_ch_d = mismatch_ch_q;
    first_fail_d  = first_fail_q;
    busy_d        = busy_q;
    done_d        = done_q;
    lfsr_load     = 1'b0;
    lfsr_adv      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_d        = mode;
          sig_d         = '0;
          mismatch_ch_d = '0;
          first_fail_d  = '0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          stim_d        = '0;
          idx_d         = '0;
          hold_d        = '0;
          lfsr_load     = 1'b1;
          state_d       = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        if (hold_q == LAST_HOLD) begin
          sig_d         = OUT_W'(misr_step(MAX_W'(sig_q), MAX_W'(y0), OUT_W));
          mismatch_ch_d = mismatch_ch_q | diff_now;
          if ((mismatch_ch_q == '0) && (diff_now != '0)) first_fail_d = idx_q;
          hold_d = '0;
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            if (!mode_q) begin
              // The LFSR already holds the next vector; hand it out and step.
              stim_d   = lfsr_val;
              lfsr_adv = 1'b1;
            end else begin
              state_d = ST_WAIT_VEC;
            end
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_WAIT_VEC: begin
        if (ext_valid) begin
          stim_d  = ext_vec;
          hold_d  = '0;
          state_d = ST_DRIVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= 1'b0;
      idx_q         <= '0;
      hold_q        <= '0;
      stim_q        <= '0;
      sig_q         <= '0;
      mismatch_ch_q <= '0;
      first_fail_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      idx_q         <= idx_d;
      hold_q        <= hold_d;
      stim_q        <= stim_d;
      sig_q         <= sig_d;
      mismatch_ch_q <= mismatch_ch_d;
      first_fail_q  <= first_fail_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign ext_ready      = (state_q == ST_WAIT_VEC);
  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mismatch_ch    = mismatch_ch_q;
  assign mismatch       = |mismatch_ch_q;
  assign first_fail_idx = first_fail_q;
  assign sig            = sig_q;

endmodule

// File: doc/diff_stim_compare.md
Name: diff_stim_compare

Overview:
- Synthesizable, parametrised stimulus player and differential checker for fuzz-equivalence runs.
- Drives one shared input vector into NUM_CH implementations of the same design, for example pre-synthesis RTL and post-synthesis netlists. Each implementation exposes one concatenated input bus and one output y.
- Samples every channel once per vector, flags any channel that differs from channel 0, and compresses channel 0's output stream into a MISR signature.
- Replaces per-run strobe dumps and offline diffing with an on-chip pass/fail result and a signature.

Parameters:
- IN_W, 255: stimulus width (concatenated DUT inputs).
- OUT_W, 152: width of each channel's y.
- NUM_CH, 2: channels compared; must be ≥2.
- NUM_VEC, 20: vectors applied after the initial all-zero vector.
- HOLD_CYC, 1: cycles each vector is held; must be ≥1.
- POLY, 'h1D: Galois LFSR tap mask, IN_W bits.
- SEED, 1: first LFSR vector; 0 is replaced by 1.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: begin a run; ignored while busy.
- mode, in, 1: 0 = LFSR stimulus, 1 = external stimulus. Sampled with start.
- ext_vec, in, IN_W: external vector.
- ext_valid, in, 1: ext_vec is valid.
- ext_ready, out, 1: block accepts ext_vec this cycle.
- stim, out, IN_W: vector driven to all channels.
- dut_y, in, NUM_CH*OUT_W: channel outputs; channel i occupies bits [i*OUT_W +: OUT_W].
- busy, out, 1: run in progress.
- done, out, 1: run finished; stays high until the next start or rst.
- mismatch, out, 1: sticky OR of mismatch_ch.
- mismatch_ch, out, NUM_CH: sticky per-channel flags; bit 0 is always 0.
- first_fail_idx, out, clog2(NUM_VEC+1): sample index of the first mismatch.
- sig, out, OUT_W: channel-0 MISR.

Behaviour:
- Reset values: every output is 0. State = IDLE; LFSR is loaded with SEED, or 1 if SEED is 0.
- States: IDLE, DRIVE, WAIT_VEC, DONE.
- IDLE/DONE + start at edge t, with mode latched:
  - clear sig, mismatch_ch and first_fail_idx; set busy=1, done=0;
  - set stim=0, vector index idx=0, hold counter=0, and reload the LFSR with SEED;
  - go to DRIVE.
- DRIVE: hold counter counts 0..HOLD_CYC-1. On the edge that ends the last hold cycle:
  - sample dut_y;
  - sig <= rotl1(sig) ^ y0;
  - for i ≥ 1, if y_i != y0, set mismatch_ch[i];
  - if this is the first mismatch of the run, first_fail_idx <= idx.
- After sampling, if idx == NUM_VEC: go to DONE, with busy=0 and done=1 on that same edge. done therefore rises at edge t+(NUM_VEC+1)*HOLD_CYC when mode=0.
- Otherwise, after sampling, idx increments and the next vector is selected:
  - mode=0: stim <= current LFSR value and the LFSR advances, so the first non-zero vector is SEED. Advance rule: next = {cur[IN_W-2:0],0} ^ (cur[IN_W-1] ? POLY : 0).
  - mode=1: go to WAIT_VEC with ext_ready=1. stim holds its previous value. On the edge where ext_valid && ext_ready, stim <= ext_vec, ext_ready drops, and the FSM returns to DRIVE with the hold counter at 0. WAIT_VEC has no timeout.
- The comparison is exact bitwise; X/Z values are not treated specially.
- start while busy: ignored.
- rst in any state: return to the reset state on that edge; partial results are discarded.
- start and rst in the same cycle: rst wins.
- ext_valid outside WAIT_VEC: ignored.

Decomposition:
- Package diff_stim_pkg holds:
  - the state enum;
  - the lfsr_step(cur, poly) and misr_step(sig, y) functions;
  - the idx width computation.
- Sub-module stim_lfsr: holds load and advance controls and implements the LFSR with the SEED==0 replacement.

Test Plan:
- Setup for every case: IN_W=8, OUT_W=8, NUM_CH=2, NUM_VEC=3, HOLD_CYC=1, POLY='h1D, SEED='h80, mode=0. Bench ties dut_y to {8'h01, 8'h01}.
  - stim sequence is 00, 80, 1D, 3A.
  - done rises 4 edges after start.
  - sig = 8'h0F, mismatch = 0.
- Same setup, channel 1 output = stim ^ (stim==8'h1D), i.e. bit 0 flipped only on the third vector, channel 0 = stim → mismatch_ch = 2'b10, first_fail_idx = 2.
- HOLD_CYC=3 → each vector is held 3 cycles; done rises 12 edges after start.
- mode=1 with ext_valid held low for 5 cycles in WAIT_VEC → stim holds 00 and ext_ready stays 1. Supplying AA, 55, FF (one handshake each) → stim shows each value; done follows the last sample.
- rst pulsed at idx=2, then start → outputs return to 0 and the full sequence repeats from 00, 80, ...
- start pulsed while busy → no effect on idx or stim. start after done → sig and mismatch flags are cleared and an identical result is reproduced.
